// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
//   DEFAULT_RESET_PC : PC loaded on reset unless overridden at instantiation
//   NOP_INST         : value presented on inst_data while no instruction is valid
//   INST_BYTES       : PC increment between sequential instructions
//   fetch_slot_t     : one queue slot at the default 32-bit widths {pc, inst, filled}
package fetch_pkg;

  localparam logic [31:0]  DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0]  NOP_INST         = 32'h0000_0000;
  localparam int unsigned  INST_BYTES       = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        filled;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction memory read channel.
//   req_valid/req_ready/req_addr : word read request (fetch side drives valid/addr)
//   rsp_valid/rsp_data           : in-order read data, latency >= 1 cycle
// Modports: master = fetch unit, slave = instruction memory.
interface fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/fetch_slot_queue.sv
// In-order slot queue for fetched instructions.
// A slot is allocated when a request is accepted (records its PC), filled when
// the matching response arrives (fill pointer trails the write pointer), and
// popped from the head once filled.
//   clk, rst     : clock, synchronous active-high reset
//   alloc        : allocate slot at wr with alloc_pc
//   fill         : write fill_inst into the oldest unfilled slot
//   pop          : retire head slot
//   flush        : discard everything (priority over alloc/fill/pop)
//   head_valid   : head slot filled and queue non-empty
//   head_pc/inst : head slot contents
//   unfilled_cnt : allocated slots still waiting for their response
//   full         : all DEPTH slots allocated
module fetch_slot_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_inst,
  input  logic              pop,
  input  logic              flush,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_inst,
  output logic [CNT_W-1:0]  unfilled_cnt,
  output logic              full
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic              filled;
  } slot_t;

  slot_t             slots [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  fill_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  alloc_cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr       <= '0;
      fill_ptr     <= '0;
      rd_ptr       <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else begin
      // alloc and fill never target the same slot: fill only points at an
      // allocated-unfilled slot, and wr reaches it only when the queue is full.
      if (alloc) begin
        slots[wr_ptr].pc     <= alloc_pc;
        slots[wr_ptr].inst   <= DATA_W'(NOP_INST);
        slots[wr_ptr].filled <= 1'b0;
        wr_ptr               <= wr_ptr + PTR_W'(1);
      end
      if (fill) begin
        slots[fill_ptr].inst   <= fill_inst;
        slots[fill_ptr].filled <= 1'b1;
        fill_ptr               <= fill_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({alloc, pop})
        2'b10:   alloc_cnt <= alloc_cnt + CNT_W'(1);
        2'b01:   alloc_cnt <= alloc_cnt - CNT_W'(1);
        default: ;
      endcase

      case ({alloc, fill})
        2'b10:   unfilled_cnt <= unfilled_cnt + CNT_W'(1);
        2'b01:   unfilled_cnt <= unfilled_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    head_valid = slots[rd_ptr].filled && (alloc_cnt != '0);
    head_pc    = slots[rd_ptr].pc;
    head_inst  = slots[rd_ptr].inst;
    full       = (alloc_cnt == CNT_W'(DEPTH));
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction
// memory, queues in-order responses and presents {inst, pc, pc+4} to decode.
// A redirect restarts fetch at redirect_pc and drops responses still owed
// for requests issued before it.
//   clk, rst                  : clock, synchronous active-high reset
//   imem (fetch_if.master)    : request/response channel to instruction memory
//   redirect_valid/pc         : taken branch/jump target (low two bits ignored)
//   inst_valid/ready          : decode handshake
//   inst_data/pc/pc_plus4     : head instruction, its PC and PC+4 (zero when idle)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter  int unsigned       ADDR_W   = 32,
  parameter  int unsigned       DATA_W   = 32,
  parameter  int unsigned       DEPTH    = 4,
  parameter  logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  localparam int unsigned       CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  fetch_if.master           imem,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_pc_plus4
);

  logic              rst_q;
  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  drop_next;
  logic [CNT_W-1:0]  unfilled_cnt;
  logic              q_full;
  logic              req_accept;
  logic              rsp_fill;
  logic              head_valid;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_inst;

  always_comb begin
    imem.req_valid = !rst_q && !redirect_valid && !q_full;
    imem.req_addr  = fetch_pc;
    req_accept     = imem.req_valid && imem.req_ready;
    rsp_fill       = imem.rsp_valid && (drop_cnt == '0);
    // Everything still owed by memory becomes stale on redirect: responses
    // already marked for dropping plus unfilled slots, less any response
    // arriving this very cycle. Adding drop_cnt keeps back-to-back redirects
    // from losing earlier stale responses.
    drop_next      = drop_cnt + unfilled_cnt - CNT_W'(imem.rsp_valid);
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      drop_cnt <= drop_next;
    end else begin
      if (req_accept) begin
        fetch_pc <= fetch_pc + ADDR_W'(INST_BYTES);
      end
      if (imem.rsp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  fetch_slot_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .alloc        (req_accept),
    .alloc_pc     (fetch_pc),
    .fill         (rsp_fill),
    .fill_inst    (imem.rsp_data),
    .pop          (inst_valid && inst_ready),
    .flush        (redirect_valid),
    .head_valid   (head_valid),
    .head_pc      (head_pc),
    .head_inst    (head_inst),
    .unfilled_cnt (unfilled_cnt),
    .full         (q_full)
  );

  always_comb begin
    inst_valid    = head_valid;
    inst_data     = head_valid ? head_inst : DATA_W'(NOP_INST);
    inst_pc       = head_valid ? head_pc : '0;
    inst_pc_plus4 = head_valid ? head_pc + ADDR_W'(INST_BYTES) : '0;
  end

endmodule
